pooling_multimode: RTL
======================

# pooling_multimode

Parametrised 2-D pooling engine for the DNN accelerator datapath. It replaces the fixed pooling block with several generalisations: runtime kernel size 1..MAX_K, max or average mode, and configurable row and column extents. It consumes a row-major stream of NUM_PE-lane words from the PE array and emits pooled words toward the output buffer. Stride always equals kernel size, so windows do not overlap, and partial column sums are held in an internal row buffer.

## Interface
- DATA_WIDTH, 16: signed bits per lane.
- NUM_PE, 4: lanes per word. Lanes are processed independently.
- MAX_K, 4: largest supported kernel edge.
- MAX_W, 64: largest input row width, in words.
- ACC_W, DATA_WIDTH+2*$clog2(MAX_K): derived accumulator width. Not overridable.
- clk, input, 1: the single clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle pulse that latches the cfg_* inputs.
- cfg_kernel, input, $clog2(MAX_K+1): kernel edge K.
- cfg_mode, input, 1: 0 selects max, 1 selects average.
- cfg_shift, input, $clog2(ACC_W): right shift applied to window sums in average mode.
- cfg_in_w, input, $clog2(MAX_W+1): input row width W, in words.
- cfg_in_h, input, 16: input row count H.
- in_data, input, DATA_WIDTH*NUM_PE: input word. Lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid / in_ready, input / output, 1: input handshake.
- out_data, output, DATA_WIDTH*NUM_PE: pooled word.
- out_valid / out_ready, output / input, 1: output handshake.
- busy, output, 1: high from an accepted start until done.
- done, output, 1: one-cycle pulse at completion.
- cfg_error, output, 1: one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE, RUN, FLUSH.
- **IDLE:**
  - start with 1≤K≤MAX_K, K≤W≤MAX_W and H≥K latches the configuration and moves to RUN.
  - Otherwise start produces a cfg_error pulse the next cycle, and the block stays in IDLE.
- **start while not IDLE:** ignored.
- **Position counters:** col (0..W-1), row (0..H-1), kx (0..K-1), ky (0..K-1), ocol (0..W/K-1). All advance only on an input handshake (in_valid && in_ready).
- **Horizontal window, per lane:**
  - At kx==0, h_acc loads the sign-extended input.
  - Otherwise h_acc becomes max(h_acc, x) in max mode, or h_acc+x in average mode.
- **Window close (kx==K-1):** the horizontal result h is combined with the row-buffer entry rb[ocol].
  - ky==0: rb[ocol] ← h.
  - 0<ky<K-1: rb[ocol] ← combine(rb[ocol], h).
  - ky==K-1: v = combine(rb[ocol], h) is written into the output register. rb is not updated.
- **Output conversion:**
  - Max mode: v truncated to DATA_WIDTH. This is lossless.
  - Average mode: v >>> cfg_shift (arithmetic), then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Trailing data:**
  - Trailing W mod K columns of each row are accepted and discarded.
  - Trailing H mod K rows are accepted and discarded.
  - Output count is floor(W/K)*floor(H/K).
- **End of input:** the last input handshake (row==H-1, col==W-1) moves RUN to FLUSH.
- **FLUSH:** waits until the output register is empty. done is then pulsed the next cycle, and the state returns to IDLE.
- **Row buffer:** MAX_W entries × NUM_PE*ACC_W bits. Combinational read, synchronous write. No reset is needed, because ky==0 always overwrites an entry before it is read.

## Timing
- **Reset values:** in_ready=0, out_valid=0, out_data=0, busy=0, done=0, cfg_error=0. State returns to IDLE and all counters clear.
- **Reset mid-operation:** aborts the run. No done pulse is produced and any pending output is dropped.
- **in_ready:** equals (state==RUN) && !(out_valid && !out_ready). The block therefore stalls only when the output register is full and not draining.
- **Throughput:** one input word per cycle with no bubbles.
- **Latency:** out_valid rises the cycle after the handshake of the word that closes a window.
- **Output register:** a single entry. The output handshake and a new window close in the same cycle are allowed: the register reloads and out_valid stays high.
- **out_data:** held stable while out_valid && !out_ready.
- **busy:** rises the cycle after an accepted start and falls together with the done pulse.
- **K==1:** output equals input (after the shift in average mode), delayed by one cycle.

## Structure
- **Shared package pooling_pkg:**
  - Mode constants POOL_MAX=0 and POOL_AVG=1.
  - State enum {IDLE, RUN, FLUSH}.
  - A function computing ACC_W.
- **Sub-module pool_lane:** the per-lane datapath, instantiated NUM_PE times via generate. It contains:
  - h_acc register;
  - combine logic (max or add);
  - shift-and-saturate logic.
- **Top level:** the FSM, counters, row buffer and output register.

## Test plan
- **Max pooling:**
  - Stimulus: K=2, max mode, W=4, H=4, lane0 values 0..15 row-major, other lanes the negated values.
  - Required: 4 outputs; lane0 = 5, 7, 13, 15; lane1 = 0, -2, -8, -10; then a done pulse.
- **Average pooling:**
  - Stimulus: K=2, average mode, shift=2, same stream.
  - Required: lane0 = 2, 4, 10, 12 (sums 10, 18, 42, 50 shifted by 2).
  - Also: an all-0x7FFF input with shift=0 saturates to 0x7FFF.
- **Backpressure:**
  - Stimulus: K=2, W=8, H=2, out_ready toggling 1-of-3 cycles.
  - Required: in_ready drops whenever the output register is held; 4 correct outputs; no loss or duplication.
- **Trailing data:**
  - Stimulus: K=2, W=5, H=5.
  - Required: all 25 inputs accepted; exactly 4 outputs; done pulses after the 25th input.
- **Invalid configuration:**
  - Stimulus: start with K=0, then with K=MAX_K+1, then with W=MAX_W+1.
  - Required: a cfg_error pulse for each; busy stays 0.
  - Also: a later legal start runs normally.
- **Reset mid-run:**
  - Stimulus: reset asserted after 5 inputs of a 4×4 K=2 run.
  - Required: all outputs at reset values the next cycle; no done pulse.
  - Also: a new run produces the correct results, confirming no stale row-buffer contamination.

Source files
------------

// File: rtl/pooling_pkg.sv
// Shared types and helpers for the multimode pooling engine.
// Mode and state encodings plus accumulator sizing.
package pooling_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  function automatic int acc_width(input int dw, input int max_k);
    return dw + 2 * $clog2(max_k);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of the pooling datapath: horizontal accumulator,
// max/add combine with the row buffer, and output conversion.
module pool_lane
  import pooling_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 20,
  parameter int SW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 first,
  input  logic                 ky_first,
  input  logic                 mode,
  input  logic [SW-1:0]        shift,
  input  logic [DW-1:0]        x,
  input  logic signed [AW-1:0] rb,
  output logic signed [AW-1:0] v,
  output logic [DW-1:0]        y
);

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] h_acc_q, h_d;
  logic signed [AW-1:0] sx, sh;

  function automatic logic signed [AW-1:0] comb(
    input logic m,
    input logic signed [AW-1:0] a,
    input logic signed [AW-1:0] b
  );
    if (m == POOL_MAX) return (a > b) ? a : b;
    return a + b;
  endfunction

  // h_d already includes the current word, so it is the
  // finished horizontal result on the closing column.
  always_comb begin
    sx  = {{(AW-DW){x[DW-1]}}, x};
    h_d = first ? sx : comb(mode, h_acc_q, sx);
    v   = ky_first ? h_d : comb(mode, rb, h_d);
    sh  = v >>> shift;
    if (mode == POOL_MAX) y = v[DW-1:0];
    else if (sh > SMAX)   y = SMAX[DW-1:0];
    else if (sh < SMIN)   y = SMIN[DW-1:0];
    else                  y = sh[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)   h_acc_q <= '0;
    else if (en) h_acc_q <= h_d;
  end

endmodule

// File: rtl/pooling_multimode.sv
// Streaming 2-D pooling engine: runtime kernel, max/avg mode,
// non-overlapping windows with a per-column row buffer.
module pooling_multimode
  import pooling_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int MAX_K      = 4,
  parameter int MAX_W      = 64,
  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_K),
  localparam int KW    = $clog2(MAX_K + 1),
  localparam int SW    = $clog2(ACC_W),
  localparam int WW    = $clog2(MAX_W + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [KW-1:0]                cfg_kernel,
  input  logic                         cfg_mode,
  input  logic [SW-1:0]                cfg_shift,
  input  logic [WW-1:0]                cfg_in_w,
  input  logic [15:0]                  cfg_in_h,
  input  logic [DATA_WIDTH*NUM_PE-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH*NUM_PE-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_error
);

  localparam int OW = $clog2(MAX_W);
  localparam int DV = DATA_WIDTH * NUM_PE;
  localparam int AV = ACC_W * NUM_PE;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     kx_q, kx_d;
  logic [KW-1:0]     ky_q, ky_d;
  logic              mode_q, mode_d;
  logic [SW-1:0]     shift_q, shift_d;
  logic [WW-1:0]     w_q, w_d;
  logic [WW-1:0]     col_q, col_d;
  logic [15:0]       h_q, h_d;
  logic [15:0]       row_q, row_d;
  logic [OW-1:0]     ocol_q, ocol_d;
  logic [DV-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_error_q, cfg_error_d;

  logic              hs, row_end, kx_end, ky_end;
  logic              last, emit, rb_we, cfg_ok;
  logic [AV-1:0]     rb_rd, rb_wd;
  logic [DV-1:0]     pooled;
  logic [AV-1:0]     rb_mem [MAX_W];

  assign in_ready  = (state_q == RUN) &&
                     !(out_valid_q && !out_ready);
  assign hs        = in_valid && in_ready;
  assign row_end   = col_q == w_q - WW'(1);
  assign kx_end    = kx_q == k_q - KW'(1);
  assign ky_end    = ky_q == k_q - KW'(1);
  assign last      = row_end && (row_q == h_q - 16'd1);
  assign emit      = hs && kx_end && ky_end;
  assign rb_we     = hs && kx_end && !ky_end;
  assign rb_rd     = rb_mem[ocol_q];

  assign cfg_ok = (cfg_kernel != '0) &&
                  (cfg_kernel <= KW'(MAX_K)) &&
                  (WW'(cfg_kernel) <= cfg_in_w) &&
                  (cfg_in_w <= WW'(MAX_W)) &&
                  (cfg_in_h >= 16'(cfg_kernel));

  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    pool_lane #(
      .DW(DATA_WIDTH),
      .AW(ACC_W),
      .SW(SW)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (hs),
      .first    (kx_q == '0),
      .ky_first (ky_q == '0),
      .mode     (mode_q),
      .shift    (shift_q),
      .x        (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .rb       (rb_rd[i*ACC_W +: ACC_W]),
      .v        (rb_wd[i*ACC_W +: ACC_W]),
      .y        (pooled[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Trailing columns never reach kx==K-1 before the row ends,
  // and trailing rows never reach ky==K-1, so no division is needed.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mode_d      = mode_q;
    shift_d     = shift_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    ocol_d      = ocol_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_error_d = 1'b0;

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = pooled;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hs) begin
      col_d  = row_end ? '0 : col_q + WW'(1);
      kx_d   = (row_end || kx_end) ? '0 : kx_q + KW'(1);
      ocol_d = row_end ? '0 :
               (kx_end ? ocol_q + OW'(1) : ocol_q);
      if (row_end) begin
        row_d = row_q + 16'd1;
        ky_d  = ky_end ? '0 : ky_q + KW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            k_d     = cfg_kernel;
            mode_d  = cfg_mode;
            shift_d = cfg_shift;
            w_d     = cfg_in_w;
            h_d     = cfg_in_h;
            col_d   = '0;
            row_d   = '0;
            kx_d    = '0;
            ky_d    = '0;
            ocol_d  = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs && last) state_d = FLUSH;
      end
      FLUSH: begin
        if (!out_valid_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      shift_q     <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      ocol_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      shift_q     <= shift_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ocol_q      <= ocol_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  // ky==0 always writes an entry before it is read, so no reset.
  always_ff @(posedge clk) begin
    if (rb_we) rb_mem[ocol_q] <= rb_wd;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_error = cfg_error_q;

endmodule
